// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive deframer
//   deframer_state_t : frame parser states
//   err_code_t       : error codes reported alongside frame_err
//   SOF_BYTE_DEFAULT : default start-of-frame marker
package uart_pkg;

    typedef enum logic [2:0] {
        S_SOF     = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_DRAIN   = 3'd4
    } deframer_state_t;

    typedef enum logic [1:0] {
        ERR_LEN     = 2'b00,
        ERR_CHK     = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_code_t;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - extracts [SOF|LEN|PAYLOAD|CHK] frames from a UART byte stream
//   clk, reset_n        : clock, synchronous active-low reset
//   in_vld, in_data     : byte strobe and byte from the UART receiver (no backpressure)
//   out_vld, out_rdy    : payload stream handshake toward the command layer
//   out_data, out_last  : payload byte and end-of-frame marker
//   frame_ok            : one-cycle pulse when a frame passes its checksum
//   frame_err, err_code : one-cycle error pulse with its LEN/CHK/TIMEOUT/OVERRUN code
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int                   DATA_BITS    = 8,
    parameter int                   MAX_LEN      = 16,
    parameter logic [DATA_BITS-1:0] SOF_BYTE     = DATA_BITS'(SOF_BYTE_DEFAULT),
    parameter int                   TIMEOUT_CLKS = 20000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_vld,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code
);

    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [DATA_BITS-1:0] MAX_LEN_B   = DATA_BITS'(MAX_LEN);
    localparam logic [TO_W-1:0]      IDLE_EXPIRY = TO_W'(TIMEOUT_CLKS - 1);

    deframer_state_t state, state_d;

    logic [DATA_BITS-1:0] payload_buf [MAX_LEN];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    // LEN-1 is kept rather than LEN so it fits the pointer width even when LEN == MAX_LEN.
    logic [PTR_W-1:0]     last_idx;
    logic [DATA_BITS-1:0] sum;
    logic [TO_W-1:0]      idle_cnt;

    logic                 frame_ok_d;
    logic                 frame_err_d;
    logic [1:0]           err_code_d;
    logic                 load_len;
    logic                 wr_en;
    logic                 rd_adv;
    logic                 timed;
    logic [DATA_BITS-1:0] chk_sum;

    always_comb begin
        state_d     = state;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code;
        load_len    = 1'b0;
        wr_en       = 1'b0;
        rd_adv      = 1'b0;
        timed       = 1'b0;
        chk_sum     = sum + in_data;

        case (state)
            S_SOF: begin
                if (in_vld && in_data == SOF_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                timed = 1'b1;
                if (in_vld) begin
                    if (in_data == '0 || in_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_SOF;
                    end else begin
                        load_len = 1'b1;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                timed = 1'b1;
                if (in_vld) begin
                    wr_en = 1'b1;
                    if (wr_ptr == last_idx) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                timed = 1'b1;
                if (in_vld) begin
                    if (chk_sum == '0) begin
                        frame_ok_d = 1'b1;
                        state_d    = S_DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = S_SOF;
                    end
                end
            end
            S_DRAIN: begin
                if (out_rdy) begin
                    rd_adv = 1'b1;
                    if (rd_ptr == last_idx) begin
                        state_d = S_SOF;
                    end
                end
                // The UART cannot be stalled, so a byte here is lost; the drain itself carries on.
                if (in_vld) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: begin
                state_d = S_SOF;
            end
        endcase

        // A byte arriving on the expiry cycle takes precedence over the timeout.
        if (timed && !in_vld && idle_cnt == IDLE_EXPIRY) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_SOF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_SOF;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_idx  <= '0;
            sum       <= '0;
            idle_cnt  <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            state     <= state_d;
            frame_ok  <= frame_ok_d;
            frame_err <= frame_err_d;
            err_code  <= err_code_d;

            if (load_len) begin
                last_idx <= PTR_W'(in_data - 1'b1);
                sum      <= in_data;
                wr_ptr   <= '0;
            end else if (wr_en) begin
                sum    <= sum + in_data;
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (frame_ok_d) begin
                rd_ptr <= '0;
            end else if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (!timed || in_vld || state_d != state) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: it is only read after being fully rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            payload_buf[wr_ptr] <= in_data;
        end
    end

    assign out_vld  = (state == S_DRAIN);
    assign out_last = (state == S_DRAIN) && (rd_ptr == last_idx);
    assign out_data = (state == S_DRAIN) ? payload_buf[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int TO = 48;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_vld;
    logic       out_rdy = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    uart_rx_deframer #(
        .DATA_BITS(8),
        .MAX_LEN(16),
        .SOF_BYTE(8'hA5),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_vld(in_vld),
        .in_data(in_data),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .out_data(out_data),
        .out_last(out_last),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       rdy;
        logic       ok;
        logic       err;
        logic [1:0] code;
        logic       ovld;
        logic [7:0] odata;
        logic       olast;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [7:0] data, input logic rdy);
        in_vld  = vld;
        in_data = data;
        out_rdy = rdy;
        @(posedge clk);
        @(negedge clk);
        in_vld  = 1'b0;
    endtask

    task automatic add(input logic vld, input logic [7:0] data, input logic rdy,
                       input logic ok, input logic err, input logic [1:0] code,
                       input logic ovld, input logic [7:0] odata, input logic olast);
        vec_t v;
        v.vld = vld; v.data = data; v.rdy = rdy;
        v.ok = ok; v.err = err; v.code = code;
        v.ovld = ovld; v.odata = odata; v.olast = olast;
        vecs.push_back(v);
    endtask

    // Byte in, no visible response expected.
    task automatic quiet(input logic [7:0] b, input logic rdy);
        add(1'b1, b, rdy, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " out_vld"},   32'(out_vld),   32'd0);
        chk({tag, " out_last"},  32'(out_last),  32'd0);
        chk({tag, " out_data"},  32'(out_data),  32'd0);
        chk({tag, " frame_ok"},  32'(frame_ok),  32'd0);
        chk({tag, " frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        bit early;

        // Good frame A5 03 11 22 33 97, sink always ready.
        quiet(8'hA5, 1); quiet(8'h03, 1); quiet(8'h11, 1); quiet(8'h22, 1); quiet(8'h33, 1);
        add(1, 8'h97, 1, 1, 0, 2'b00, 1, 8'h11, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 1, 8'h22, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 1, 8'h33, 1);
        add(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        // Bad checksum then a good frame.
        quiet(8'hA5, 1); quiet(8'h03, 1); quiet(8'h11, 1); quiet(8'h22, 1); quiet(8'h33, 1);
        add(1, 8'h98, 1, 0, 1, ERR_CHK, 0, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        quiet(8'hA5, 1); quiet(8'h03, 1); quiet(8'h11, 1); quiet(8'h22, 1); quiet(8'h33, 1);
        add(1, 8'h97, 1, 1, 0, 2'b00, 1, 8'h11, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 1, 8'h22, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 1, 8'h33, 1);
        add(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        // Garbage dropped silently, then LEN=0 and LEN=17 rejected.
        quiet(8'h00, 1); quiet(8'hFF, 1);
        quiet(8'hA5, 1);
        add(1, 8'h00, 1, 0, 1, ERR_LEN, 0, 8'h00, 0);
        quiet(8'hA5, 1);
        add(1, 8'h11, 1, 0, 1, ERR_LEN, 0, 8'h00, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        // LEN=1 frame: 01+7E=7F, checksum 81.
        quiet(8'hA5, 1); quiet(8'h01, 1); quiet(8'h7E, 1);
        add(1, 8'h81, 1, 1, 0, 2'b00, 1, 8'h7E, 1);
        add(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        // SOF value inside LEN-2 payload is data: 02+A5+A5=4C, checksum B4.
        quiet(8'hA5, 1); quiet(8'h02, 1); quiet(8'hA5, 1); quiet(8'hA5, 1);
        add(1, 8'hB4, 1, 1, 0, 2'b00, 1, 8'hA5, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 1, 8'hA5, 1);
        add(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);
        // Backpressure for 10 cycles with an overrun byte 5A, then drain.
        quiet(8'hA5, 0); quiet(8'h03, 0); quiet(8'h11, 0); quiet(8'h22, 0); quiet(8'h33, 0);
        add(1, 8'h97, 0, 1, 0, 2'b00, 1, 8'h11, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) add(1, 8'h5A, 0, 0, 1, ERR_OVERRUN, 1, 8'h11, 0);
            else        add(0, 8'h00, 0, 0, 0, 2'b00,       1, 8'h11, 0);
        end
        add(0, 8'h00, 1, 0, 0, 2'b00, 1, 8'h22, 0);
        add(0, 8'h00, 1, 0, 0, 2'b00, 1, 8'h33, 1);
        add(0, 8'h00, 1, 0, 0, 2'b00, 0, 8'h00, 0);

        // Reset state.
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        check_idle_outputs("reset");
        chk("reset err_code", 32'(err_code), 32'd0);
        chk("reset state", 32'(dut.state), 32'(S_SOF));
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].vld, vecs[i].data, vecs[i].rdy);
            chk($sformatf("vec%0d frame_ok", i),  32'(frame_ok),  32'(vecs[i].ok));
            chk($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].err));
            if (vecs[i].err)
                chk($sformatf("vec%0d err_code", i), 32'(err_code), 32'(vecs[i].code));
            chk($sformatf("vec%0d out_vld", i),   32'(out_vld),   32'(vecs[i].ovld));
            chk($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].odata));
            chk($sformatf("vec%0d out_last", i),  32'(out_last),  32'(vecs[i].olast));
        end

        // Timeout fires exactly TO idle cycles after the last byte.
        step(1, 8'hA5, 1); step(1, 8'h03, 1); step(1, 8'h11, 1);
        early = 1'b0;
        for (int i = 1; i < TO; i++) begin
            step(0, 8'h00, 1);
            if (frame_err) early = 1'b1;
        end
        chk("timeout not early", 32'(early), 32'd0);
        step(0, 8'h00, 1);
        chk("timeout frame_err", 32'(frame_err), 32'd1);
        chk("timeout err_code", 32'(err_code), 32'(ERR_TIMEOUT));
        step(0, 8'h00, 1);
        chk("timeout pulse width", 32'(frame_err), 32'd0);
        chk("timeout state", 32'(dut.state), 32'(S_SOF));

        // Byte landing on the expiry cycle wins; frame still completes.
        step(1, 8'hA5, 1); step(1, 8'h03, 1); step(1, 8'h11, 1);
        for (int i = 1; i < TO; i++) step(0, 8'h00, 1);
        step(1, 8'h22, 1);
        chk("expiry byte wins", 32'(frame_err), 32'd0);
        step(1, 8'h33, 1);
        step(1, 8'h97, 1);
        chk("expiry frame_ok", 32'(frame_ok), 32'd1);
        chk("expiry out_data", 32'(out_data), 32'h11);
        step(0, 8'h00, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);
        chk("expiry drained", 32'(out_vld), 32'd0);

        // Reset mid-payload discards the frame; the tail bytes produce nothing.
        step(1, 8'hA5, 1); step(1, 8'h03, 1); step(1, 8'h11, 1);
        reset_n = 1'b0;
        step(0, 8'h00, 1);
        reset_n = 1'b1;
        check_idle_outputs("midreset");
        chk("midreset state", 32'(dut.state), 32'(S_SOF));
        step(1, 8'h22, 1); step(1, 8'h33, 1); step(1, 8'h97, 1);
        check_idle_outputs("after reset tail");
        step(0, 8'h00, 1);
        check_idle_outputs("after reset idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
